// File: rtl/cpu_pipe_pkg.sv
// Shared IF/ID pipeline definitions: bundle layout, register-field positions, bubble word.
package cpu_pipe_pkg;

  localparam int BUNDLE_W  = 64;
  localparam int PC4_LSB   = 0;
  localparam int INSTR_LSB = 32;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    HZ_NONE,
    HZ_LOADUSE
  } hazard_t;

endpackage

// File: rtl/id_bundle_reader_if.sv
// IF->reader and reader->ID/EX handshake bundle.
// Valid/ready: a transfer happens at the posedge where valid & ready are both 1;
// the sender holds its data stable while valid=1 and ready=0, and ready never
// depends combinationally on valid.
interface id_bundle_reader_if;
  import cpu_pipe_pkg::*;

  logic [BUNDLE_W-1:0] in_bundle;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         out_instr;
  logic [31:0]         out_pc4;
  logic [4:0]          out_rs;
  logic [4:0]          out_rt;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_bundle, in_valid, out_ready,
    input  in_ready, out_instr, out_pc4, out_rs, out_rt, out_valid
  );

  modport slave (
    input  in_bundle, in_valid, out_ready,
    output in_ready, out_instr, out_pc4, out_rs, out_rt, out_valid
  );
endinterface

// File: rtl/bundle_fifo2.sv
// Two-entry bundle buffer with wrapping read/write pointers and an occupancy count.
module bundle_fifo2
  import cpu_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [BUNDLE_W-1:0] wr_data,
  output logic [BUNDLE_W-1:0] rd_data,
  output logic [CNT_W-1:0]    count,
  output logic                full
);

  logic [BUNDLE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & !full;
  assign do_pop  = pop & (count != '0);
  assign rd_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Redirect: contents become stale, only the bookkeeping needs resetting.
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/id_bundle_reader.sv
// ID-side consumer of IF/ID bundles: buffering, unpacking and back-pressure toward IF.
// Optional load-use stall gate is built when HAZARD_DETECT_EN is defined.
module id_bundle_reader
  import cpu_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    flush,
  output logic [1:0]              count,
`ifdef HAZARD_DETECT_EN
  input  logic                    ex_memread,
  input  logic [4:0]              ex_rt,
  output logic                    stall,
`endif
  id_bundle_reader_if.slave       bus
);

  logic [BUNDLE_W-1:0] head;
  logic [31:0]         head_instr;
  logic [31:0]         head_pc4;
  logic                full;
  logic                have;
  logic                hold;

  bundle_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .flush   (flush),
    .push    (bus.in_valid & bus.in_ready),
    .pop     (bus.out_valid & bus.out_ready),
    .wr_data (bus.in_bundle),
    .rd_data (head),
    .count   (count),
    .full    (full)
  );

  assign head_instr = head[INSTR_LSB +: 32];
  assign head_pc4   = head[PC4_LSB +: 32];
  assign have       = (count != 2'd0);

`ifdef HAZARD_DETECT_EN
  hazard_t hz;

  always_comb begin
    hz = HZ_NONE;
    if (have && ex_memread && (ex_rt != 5'd0) &&
        ((ex_rt == head_instr[RS_MSB:RS_LSB]) || (ex_rt == head_instr[RT_MSB:RT_LSB])))
      hz = HZ_LOADUSE;
  end

  assign stall = (hz == HZ_LOADUSE);
  assign hold  = stall;
`else
  assign hold  = 1'b0;
`endif

  // in_ready is registered-state only so IF never sees a path from out_ready.
  assign bus.in_ready  = !clr & !full;
  assign bus.out_valid = !clr & have & !flush & !hold;
  assign bus.out_instr = bus.out_valid ? head_instr : NOP_WORD;
  assign bus.out_pc4   = bus.out_valid ? head_pc4 : 32'h0;
  assign bus.out_rs    = bus.out_valid ? head_instr[RS_MSB:RS_LSB] : 5'd0;
  assign bus.out_rt    = bus.out_valid ? head_instr[RT_MSB:RT_LSB] : 5'd0;

endmodule

// File: tb/tb_id_bundle_reader.sv
// Directed-vector bench for id_bundle_reader (hazard vectors added under HAZARD_DETECT_EN).
module tb_id_bundle_reader;
  import cpu_pipe_pkg::*;

  logic       clk;
  logic       clr;
  logic       flush;
  logic [1:0] count;
`ifdef HAZARD_DETECT_EN
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       stall;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  id_bundle_reader_if bus ();

  id_bundle_reader dut (
    .clk        (clk),
    .clr        (clr),
    .flush      (flush),
    .count      (count),
`ifdef HAZARD_DETECT_EN
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .stall      (stall),
`endif
    .bus        (bus.slave)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc4);
    bus.in_bundle = {instr, pc4};
    bus.in_valid  = 1'b1;
  endtask

  initial begin
    logic accepted;

    // reset with IF offering data
    clr           = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
`ifdef HAZARD_DETECT_EN
    ex_memread = 1'b0;
    ex_rt      = 5'd0;
`endif
    offer(32'hDEAD_BEEF, 32'h4);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_out_valid2", bus.out_valid, 0);
    chk("rst_out_pc4", bus.out_pc4, 0);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_release_in_ready", bus.in_ready, 1);
    chk("empty_out_valid", bus.out_valid, 0);

    // single transfer, one-cycle latency
    bus.out_ready = 1'b1;
    offer(32'h8C22_0004, 32'h0000_0008);
    #1;
    chk("single_no_bypass", bus.out_valid, 0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("single_valid", bus.out_valid, 1);
    chk("single_instr", bus.out_instr, 32'h8C22_0004);
    chk("single_rs", bus.out_rs, 1);
    chk("single_rt", bus.out_rt, 2);
    chk("single_pc4", bus.out_pc4, 8);
    chk("single_count", count, 1);
    step();
    chk("single_drained", count, 0);
    chk("single_bubble_instr", bus.out_instr, 0);
    chk("single_bubble_rs", bus.out_rs, 0);

    // back-pressure: fill with A, B, then C waits at IF
    bus.out_ready = 1'b0;
    offer(32'h1111_1111, 32'h100);
    step();
    offer(32'h2222_2222, 32'h104);
    step();
    offer(32'h3333_3333, 32'h108);
    #1;
    chk("bp_full_count", count, 2);
    chk("bp_full_in_ready", bus.in_ready, 0);
    step();
    chk("bp_hold_count", count, 2);
    chk("bp_hold_head", bus.out_pc4, 32'h100);
    exp_q = '{32'h100, 32'h104, 32'h108};
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
      #1;
      if (bus.out_valid && bus.out_ready) chk("bp_order", bus.out_pc4, exp_q.pop_front());
      accepted = bus.in_valid & bus.in_ready;
      step();
      if (accepted) bus.in_valid = 1'b0;
    end
    chk("bp_all_seen", exp_q.size(), 0);
    chk("bp_end_count", count, 0);
    chk("bp_no_dup", bus.out_valid, 0);

    // simultaneous push/pop at count 1
    bus.out_ready = 1'b0;
    offer(32'h0000_0000, 32'h200);
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(32'h0000_0000, 32'h204 + 32'(4 * i));
      #1;
      chk("pp_pc4", bus.out_pc4, 32'h200 + 64'(4 * i));
      step();
      chk("pp_count", count, 1);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("pp_last_pc4", bus.out_pc4, 32'h220);
    step();
    chk("pp_drained", count, 0);

    // flush at full with IF offering a bundle
    bus.out_ready = 1'b0;
    offer(32'h0, 32'h300);
    step();
    offer(32'h0, 32'h304);
    step();
    offer(32'h0, 32'h308);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("flush_out_valid", bus.out_valid, 0);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_out_valid_next", bus.out_valid, 0);
    offer(32'h0, 32'h30C);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("flush_next_pc4", bus.out_pc4, 32'h30C);
    step();

    // clr and flush together mid-transfer
    bus.out_ready = 1'b0;
    offer(32'h5555_5555, 32'h500);
    step();
    clr   = 1'b1;
    flush = 1'b1;
    step();
    clr          = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("clr_flush_count", count, 0);
    chk("clr_flush_out_valid", bus.out_valid, 0);

`ifdef HAZARD_DETECT_EN
    // load-use stall on head rt
    offer(32'h0022_1820, 32'h400);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    ex_memread    = 1'b1;
    ex_rt         = 5'd2;
    #1;
    chk("hz_stall", stall, 1);
    chk("hz_bubble", bus.out_valid, 0);
    step();
    chk("hz_held_count", count, 1);
    ex_memread = 1'b0;
    #1;
    chk("hz_release_stall", stall, 0);
    chk("hz_release_valid", bus.out_valid, 1);
    chk("hz_release_pc4", bus.out_pc4, 32'h400);
    step();
    chk("hz_issued_count", count, 0);

    // ex_rt = 0 never stalls
    bus.out_ready = 1'b0;
    offer(32'h0022_1820, 32'h404);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    ex_memread    = 1'b1;
    ex_rt         = 5'd0;
    #1;
    chk("hz_r0_stall", stall, 0);
    chk("hz_r0_valid", bus.out_valid, 1);
    step();
    ex_memread = 1'b0;
    chk("hz_r0_count", count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_bundle_reader.md
Name: id_bundle_reader

Overview:
ID-side consumer of the 64-bit IF/ID bundle (bits [31:0] = PC+4, bits [63:32] = instruction).
- Buffers bundles in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Unpacks the head entry into instruction, PC+4 and rs/rt fields for the decode stage.
- Drives back-pressure (in_ready) toward IF so fetch can stall without losing instructions.

Parameters:
DEPTH, 2, FIFO entries; fixed at 2, with log2 pointer width derived from it.
NOP_WORD, 32'h0000_0000, instruction value driven on out_instr when no valid entry is presented.

Ports:
clk  in  1  rising-edge clock
clr  in  1  reset, synchronous, active-high
in_bundle  in  64  [31:0] PC+4, [63:32] instruction
in_valid  in  1  IF offers in_bundle this cycle
in_ready  out  1  reader can accept this cycle
flush  in  1  discard all buffered and incoming bundles (branch/jump redirect)
out_instr  out  32  head instruction, or NOP_WORD when out_valid=0
out_pc4  out  32  head PC+4, or 0 when out_valid=0
out_rs  out  5  out_instr[25:21]
out_rt  out  5  out_instr[20:16]
out_valid  out  1  head presented to ID/EX
out_ready  in  1  ID/EX accepts this cycle
count  out  2  entries held (0..2)

Behaviour:
- Reset (clr=1 at posedge): count=0, rd_ptr=wr_ptr=0, storage cleared to 0. While clr=1: in_ready=0, out_valid=0, out_instr=NOP_WORD, out_pc4=0.
- Push: in_valid & in_ready. Pop: out_valid & out_ready. Both take effect at the posedge.
- in_ready = !clr & (count != 2), from registers only; no combinational path from out_ready.
- out_valid = (count != 0) & !flush (further gated by the optional feature).
- Latency: a bundle pushed at edge N is presented on out_* at N+1. There is no same-cycle bypass.
- Push at count 0 or 1: write entry[wr_ptr], wr_ptr toggles.
- Pop: rd_ptr toggles. Pointers wrap modulo 2.
- Push and pop together at count 1: count stays 1 and FIFO order is preserved.
- Full (count 2): in_ready=0, so in_valid is ignored and the bundle must be held by IF.
- Empty (count 0): out_ready is ignored and outputs show the bubble (NOP_WORD / 0).
- flush=1 overrides everything:
  - out_valid=0 that cycle; no pop and no push.
  - Next cycle: count=0 and pointers reset to 0.
  - flush and clr together: clr wins, same end state.
- Reset mid-transfer drops all entries; no partial bundle survives.
- Fields are a pure slice of the head entry: out_rs/out_rt are 0 when out_valid=0.

Optional Feature:
Macro HAZARD_DETECT_EN.
- Defined:
  - Adds ports ex_memread (in, 1) and ex_rt (in, 5).
  - Load-use stall when count!=0 & ex_memread & ex_rt!=0 & (ex_rt==head rs | ex_rt==head rt).
  - On stall: out_valid=0 (bubble into ID/EX), head is held, no pop, push still allowed when not full.
  - Adds output stall (out, 1) mirroring the stall condition.
- Undefined: these ports are absent and out_valid = (count!=0) & !flush.

Decomposition:
- Package cpu_pipe_pkg holds:
  - bundle field constants: PC4_LSB=0, INSTR_LSB=32, BUNDLE_W=64
  - RS_MSB/LSB=25/21, RT_MSB/LSB=20/16
  - NOP_WORD
  - hazard_t enum {HZ_NONE, HZ_LOADUSE}
- One natural sub-module, bundle_fifo2: generic 2-entry, 64-bit storage with pointers and count.
- id_bundle_reader wraps bundle_fifo2 with unpacking, flush and the hazard gate.

Test Plan:
- Reset: assert clr 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_instr=0, count=0; then deassert -> in_ready=1.
- Single transfer: push {instr=32'h8C22_0004, pc4=32'h0000_0008} at edge N with out_ready=1 -> at N+1 out_valid=1, out_rs=1, out_rt=2, out_pc4=8; popped at N+1, count=0 at N+2.
- Back-pressure: out_ready=0, push A then B -> count=2, in_ready=0, C held by IF. Release out_ready -> order A, B, C with nothing lost or duplicated.
- Simultaneous push/pop at count=1 for 8 cycles with an incrementing pc4 -> count stays 1, output pc4 sequence strictly +4.
- Flush at count=2 with in_valid=1 -> out_valid=0 that cycle, count=0 next cycle, flushed-cycle bundle absent from output.
- HAZARD_DETECT_EN: head instr 32'h0022_1820 (rs=1, rt=2), ex_memread=1, ex_rt=2 -> stall=1, out_valid=0 for one cycle; ex_memread=0 next cycle -> head issues. Same stimulus with ex_rt=0 -> no stall.
